data_mem_responder: RTL and testbench

- Memory-side responder for the CPU core's data memory port. It accepts the core's read and write requests, services them from an internal word-organised SRAM array with a configurable number of wait states, and drives the stall handshake back into the core's data stall input.
- It sits between `cpu_core` and on-chip data RAM. It is the other end of the core's data_mem_* interface.

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Purpose: data-memory responder for the CPU core, serving reads and writes from an internal word SRAM.
// Latency: a legal request stalls for WAIT_STATES+2 cycles and an illegal one for 1 cycle; the response follows in the DONE cycle.
// Backpressure: stall_out holds the core while a request is in flight; data_mem_stall_in keeps DONE and its outputs stable.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        cpu_clk_in,
    input  logic        master_reset_n,
    input  logic [31:0] data_mem_addr_in,
    input  logic [31:0] data_mem_data_in,
    input  logic [3:0]  data_mem_be_in,
    input  logic        data_mem_write_in,
    input  logic        data_mem_read_in,
    input  logic        data_mem_stall_in,
    output logic [31:0] data_mem_data_out,
    output logic        data_mem_stall_out,
    output logic        data_mem_err_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    logic [31:0]           mem [DEPTH];
    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  req;
    logic                  illegal;

    assign req = data_mem_read_in | data_mem_write_in;

    // Reject conflicting ops, misaligned addresses and addresses beyond the array.
    always_comb begin
        illegal = 1'b0;
        if (data_mem_read_in && data_mem_write_in)
            illegal = 1'b1;
        if (data_mem_addr_in[1:0] != 2'b00)
            illegal = 1'b1;
        if ((data_mem_addr_in >> (ADDR_WIDTH + 2)) != 32'd0)
            illegal = 1'b1;
    end

    // Stall is raised the same cycle a request appears, so the core freezes immediately.
    always_comb begin
        data_mem_stall_out = 1'b0;
        case (state)
            S_IDLE:   data_mem_stall_out = req;
            S_WAIT:   data_mem_stall_out = 1'b1;
            S_ACCESS: data_mem_stall_out = 1'b1;
            default:  data_mem_stall_out = 1'b0;
        endcase
    end

    // Request sequencing: latch the request, count wait states, access, then present the response.
    always_ff @(posedge cpu_clk_in or negedge master_reset_n) begin
        if (!master_reset_n) begin
            state             <= S_IDLE;
            wait_cnt          <= 4'd0;
            op_write          <= 1'b0;
            word_idx          <= '0;
            wdata_q           <= 32'd0;
            be_q              <= 4'd0;
            data_mem_data_out <= 32'd0;
            data_mem_err_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_write         <= data_mem_write_in;
                        word_idx         <= data_mem_addr_in[ADDR_WIDTH+1:2];
                        wdata_q          <= data_mem_data_in;
                        be_q             <= data_mem_be_in;
                        data_mem_err_out <= 1'b0;
                        if (illegal) begin
                            data_mem_err_out  <= 1'b1;
                            data_mem_data_out <= 32'd0;
                            state             <= S_DONE;
                        end else if (WAIT_STATES > 0) begin
                            wait_cnt <= 4'(WAIT_STATES);
                            state    <= S_WAIT;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1)
                        state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!op_write)
                        data_mem_data_out <= mem[word_idx];
                    state <= S_DONE;
                end
                default: begin
                    if (!data_mem_stall_in)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-masked array write on the ACCESS edge; the array itself is never reset.
    always_ff @(posedge cpu_clk_in) begin
        if (state == S_ACCESS && op_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i])
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rd_a, wr_a, rd_b, wr_b, stall_in;
    logic [31:0] a_dout, b_dout;
    logic        a_stall, b_stall, a_err, b_err;

    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Unit A: one wait state.
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
        .cpu_clk_in         (clk),
        .master_reset_n     (rst_a_n),
        .data_mem_addr_in   (addr),
        .data_mem_data_in   (wdata),
        .data_mem_be_in     (be),
        .data_mem_write_in  (wr_a),
        .data_mem_read_in   (rd_a),
        .data_mem_stall_in  (stall_in),
        .data_mem_data_out  (a_dout),
        .data_mem_stall_out (a_stall),
        .data_mem_err_out   (a_err)
    );

    // Unit B: zero wait states.
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .cpu_clk_in         (clk),
        .master_reset_n     (rst_b_n),
        .data_mem_addr_in   (addr),
        .data_mem_data_in   (wdata),
        .data_mem_be_in     (be),
        .data_mem_write_in  (wr_b),
        .data_mem_read_in   (rd_b),
        .data_mem_stall_in  (1'b0),
        .data_mem_data_out  (b_dout),
        .data_mem_stall_out (b_stall),
        .data_mem_err_out   (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: returns the number of stalled cycles and the DONE-cycle response.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int nstall, output logic [31:0] dout, output logic err);
        @(negedge clk);
        addr  = a;
        wdata = d;
        be    = b;
        if (sel) begin rd_b = rd; wr_b = wr; end
        else     begin rd_a = rd; wr_a = wr; end
        #1;
        nstall = 0;
        while ((sel ? b_stall : a_stall) && nstall < 40) begin
            nstall++;
            @(negedge clk);
            #1;
        end
        dout = sel ? b_dout : a_dout;
        err  = sel ? b_err : a_err;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    endtask

    int          ns;
    logic [31:0] dv;
    logic        ev;
    logic [31:0] bad_addr [3];
    logic        bad_rd   [3];
    logic        bad_wr   [3];

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        addr = 32'd0; wdata = 32'd0; be = 4'd0;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        stall_in = 1'b0;

        // Reset state, during and after reset with no request.
        #12;
        check("rst_dout", a_dout, 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_b_dout", b_dout, 32'd0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_dout", a_dout, 32'd0);
        check("idle_err", 32'(a_err), 32'd0);
        check("idle_stall", 32'(a_stall), 32'd0);

        // Full write then read back.
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, ns, dv, ev);
        check("wr_stalls", 32'(ns), 32'd3);
        check("wr_err", 32'(ev), 32'd0);
        check("wr_dout_unchanged", dv, 32'd0);
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, ns, dv, ev);
        check("rd_stalls", 32'(ns), 32'd3);
        check("rd_data", dv, 32'hDEADBEEF);
        check("rd_err", 32'(ev), 32'd0);

        // Byte-enable merge, then an empty byte mask.
        txn(0, 0, 1, 32'h10, 32'h11223344, 4'b0101, ns, dv, ev);
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, ns, dv, ev);
        check("be_merge", dv, 32'hDE22BE44);
        txn(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, ns, dv, ev);
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, ns, dv, ev);
        check("be_none", dv, 32'hDE22BE44);

        // Restore word 0x10 and seed word 0x14.
        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, ns, dv, ev);
        txn(0, 0, 1, 32'h14, 32'h55AA00FF, 4'hF, ns, dv, ev);
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, ns, dv, ev);
        check("restore", dv, 32'hDEADBEEF);

        // Illegal requests: misaligned, out of range, read and write together.
        bad_addr[0] = 32'h13;   bad_rd[0] = 1'b1; bad_wr[0] = 1'b0;
        bad_addr[1] = 32'h1000; bad_rd[1] = 1'b1; bad_wr[1] = 1'b0;
        bad_addr[2] = 32'h10;   bad_rd[2] = 1'b1; bad_wr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            txn(0, bad_rd[i], bad_wr[i], bad_addr[i], 32'h12345678, 4'hF, ns, dv, ev);
            check($sformatf("ill%0d_stalls", i), 32'(ns), 32'd1);
            check($sformatf("ill%0d_err", i), 32'(ev), 32'd1);
            check($sformatf("ill%0d_dout", i), dv, 32'd0);
        end
        txn(0, 1, 0, 32'h10, 32'h0, 4'h0, ns, dv, ev);
        check("ill_word_intact", dv, 32'hDEADBEEF);
        check("ill_err_cleared", 32'(ev), 32'd0);

        // Response backpressure, with the read held asserted throughout DONE.
        @(negedge clk);
        addr = 32'h10; rd_a = 1'b1; stall_in = 1'b1;
        #1;
        ns = 0;
        while (a_stall && ns < 40) begin ns++; @(negedge clk); #1; end
        check("bp_stalls", 32'(ns), 32'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_hold_stall%0d", k), 32'(a_stall), 32'd0);
            check($sformatf("bp_hold_data%0d", k), a_dout, 32'hDEADBEEF);
            @(negedge clk);
            #1;
        end
        // Release backpressure with the next request already presented.
        addr = 32'h14; stall_in = 1'b0;
        #1;
        check("bp_release_stall", 32'(a_stall), 32'd0);
        ns = 0;
        @(negedge clk); #1;
        while (a_stall && ns < 40) begin ns++; @(negedge clk); #1; end
        check("b2b_1_stalls", 32'(ns), 32'd3);
        check("b2b_1_data", a_dout, 32'h55AA00FF);
        addr = 32'h10;
        ns = 0;
        @(negedge clk); #1;
        while (a_stall && ns < 40) begin ns++; @(negedge clk); #1; end
        check("b2b_2_stalls", 32'(ns), 32'd3);
        check("b2b_2_data", a_dout, 32'hDEADBEEF);
        rd_a = 1'b0;

        // Reset during WAIT of a write drops the write.
        txn(0, 0, 1, 32'h20, 32'h01234567, 4'hF, ns, dv, ev);
        txn(0, 1, 0, 32'h14, 32'h0, 4'h0, ns, dv, ev);
        @(negedge clk);
        addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF; wr_a = 1'b1;
        @(negedge clk); #1;
        check("mid_a_wait_stall", 32'(a_stall), 32'd1);
        check("mid_a_pre_dout", a_dout, 32'h55AA00FF);
        #1;
        rst_a_n = 1'b0; wr_a = 1'b0;
        #1;
        check("mid_a_dout", a_dout, 32'd0);
        check("mid_a_err", 32'(a_err), 32'd0);
        check("mid_a_stall", 32'(a_stall), 32'd0);
        @(negedge clk);
        rst_a_n = 1'b1;
        txn(0, 1, 0, 32'h20, 32'h0, 4'h0, ns, dv, ev);
        check("mid_a_readback", dv, 32'h01234567);

        // Zero wait states: two-cycle stall timing and reset during ACCESS.
        txn(1, 0, 1, 32'h20, 32'h0BADF00D, 4'hF, ns, dv, ev);
        check("b_wr_stalls", 32'(ns), 32'd2);
        txn(1, 1, 0, 32'h20, 32'h0, 4'h0, ns, dv, ev);
        check("b_rd_stalls", 32'(ns), 32'd2);
        check("b_rd_data", dv, 32'h0BADF00D);
        txn(1, 1, 0, 32'h2, 32'h0, 4'h0, ns, dv, ev);
        check("b_ill_stalls", 32'(ns), 32'd1);
        check("b_ill_err", 32'(ev), 32'd1);
        txn(1, 1, 0, 32'h20, 32'h0, 4'h0, ns, dv, ev);
        check("b_rd2_data", dv, 32'h0BADF00D);
        @(negedge clk);
        addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF; wr_b = 1'b1;
        #1;
        check("mid_b_idle_stall", 32'(b_stall), 32'd1);
        @(negedge clk); #1;
        check("mid_b_access_stall", 32'(b_stall), 32'd1);
        rst_b_n = 1'b0; wr_b = 1'b0;
        #1;
        check("mid_b_dout", b_dout, 32'd0);
        check("mid_b_stall", 32'(b_stall), 32'd0);
        check("mid_b_err", 32'(b_err), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        txn(1, 1, 0, 32'h20, 32'h0, 4'h0, ns, dv, ev);
        check("mid_b_readback", dv, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
